// File: rtl/nx_stream_combiner_pkg.sv
// ==== nx_stream_combiner_pkg : node message and direction types for the stream combiner ====
// ==== Rev 1.0                                                                           ====
`default_nettype none

package nx_stream_combiner_pkg;

   localparam int MESSAGE_WIDTH = 32;
   localparam int DIR_WIDTH     = 2;

   typedef logic [MESSAGE_WIDTH-1:0] node_message_t;

   typedef enum logic [DIR_WIDTH-1:0] {
      DIRECTION_NORTH = 2'd0,
      DIRECTION_EAST  = 2'd1,
      DIRECTION_SOUTH = 2'd2,
      DIRECTION_WEST  = 2'd3
   } direction_t;

   function automatic direction_t idx_to_dir(input logic [DIR_WIDTH-1:0] idx);
      return direction_t'(idx);
   endfunction

endpackage

`default_nettype wire

// File: rtl/nx_arbiter_rr.sv
// ==== nx_arbiter_rr : round-robin (or fixed-priority with NX_STREAM_COMBINER_FIXED_PRIORITY_EN) ====
// ==== one-hot arbiter with encoded grant index; Rev 1.0                                         ====
`default_nettype none

module nx_arbiter_rr
   import nx_stream_combiner_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [WIDTH-1:0]         i_req,
   input  logic                     i_update,
   input  logic [$clog2(WIDTH)-1:0] i_grant_idx,
   output logic [WIDTH-1:0]         o_grant,
   output logic [$clog2(WIDTH)-1:0] o_grant_idx
);

   localparam int c_IDX_W = $clog2(WIDTH);

   logic w_found;

`ifdef NX_STREAM_COMBINER_FIXED_PRIORITY_EN

   logic w_unused;
   assign w_unused = ^{i_clk, i_rst, i_update, i_grant_idx};

   // Lowest requesting index wins.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      w_found     = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!w_found && i_req[c_IDX_W'(i)]) begin
            w_found                 = 1'b1;
            o_grant[c_IDX_W'(i)]    = 1'b1;
            o_grant_idx             = c_IDX_W'(i);
         end
      end
   end

`else

   logic [c_IDX_W-1:0] ptr_q;
   logic [c_IDX_W-1:0] ptr_d;
   logic [c_IDX_W-1:0] w_pos;

   always_comb begin
      ptr_d = ptr_q;
      if (i_update) begin
         ptr_d = i_grant_idx;
      end
   end

   // Pointer rests on the last winner so its successor has first claim.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ptr_q <= c_IDX_W'(WIDTH-1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      w_found     = 1'b0;
      w_pos       = '0;
      for (int k = 1; k <= WIDTH; k++) begin
         w_pos = c_IDX_W'((int'(ptr_q) + k) % WIDTH);
         if (!w_found && i_req[w_pos]) begin
            w_found        = 1'b1;
            o_grant[w_pos] = 1'b1;
            o_grant_idx    = w_pos;
         end
      end
   end

`endif

endmodule

`default_nettype wire

// File: rtl/nx_stream_combiner.sv
// ==== nx_stream_combiner : merges up to four node streams into one direction-tagged stream ====
// ==== Optional macro NX_STREAM_COMBINER_FIXED_PRIORITY_EN; Rev 1.0                          ====
`default_nettype none

module nx_stream_combiner
   import nx_stream_combiner_pkg::*;
#(
   parameter int STREAMS = 4
)
(
   input  logic                        i_clk,
   input  logic                        i_rst,
   output logic                        o_idle,
   input  node_message_t [STREAMS-1:0] i_inbound_data,
   input  logic [STREAMS-1:0]          i_inbound_valid,
   output logic [STREAMS-1:0]          o_inbound_ready,
   output direction_t                  o_outbound_dir,
   output node_message_t               o_outbound_data,
   output logic                        o_outbound_valid,
   input  logic                        i_outbound_ready
);

   localparam int c_IDX_W = $clog2(STREAMS);

   logic [STREAMS-1:0]  w_grant;
   logic [c_IDX_W-1:0]  w_grant_idx;
   logic                w_slot_free;
   logic                w_accept;

   node_message_t       data_q;
   node_message_t       data_d;
   direction_t          dir_q;
   direction_t          dir_d;
   logic                valid_q;
   logic                valid_d;

   nx_arbiter_rr #(
      .WIDTH       (STREAMS)
   ) u_arbiter (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       (i_inbound_valid),
      .i_update    (w_accept),
      .i_grant_idx (w_grant_idx),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx)
   );

   // The slot can take a new message when empty or when it drains this cycle.
   assign w_slot_free     = !valid_q || i_outbound_ready;
   assign o_inbound_ready = {STREAMS{w_slot_free}} & w_grant;
   assign w_accept        = |o_inbound_ready;

   always_comb begin
      data_d  = data_q;
      dir_d   = dir_q;
      valid_d = valid_q;
      if (w_accept) begin
         data_d  = i_inbound_data[w_grant_idx];
         dir_d   = idx_to_dir(DIR_WIDTH'(w_grant_idx));
         valid_d = 1'b1;
      end else if (i_outbound_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         data_q  <= '0;
         dir_q   <= DIRECTION_NORTH;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         dir_q   <= dir_d;
         valid_q <= valid_d;
      end
   end

   assign o_outbound_data  = data_q;
   assign o_outbound_dir   = dir_q;
   assign o_outbound_valid = valid_q;
   assign o_idle           = !valid_q && !(|i_inbound_valid);

endmodule

`default_nettype wire

// File: tb/tb_nx_stream_combiner.sv
// ==== tb_nx_stream_combiner : directed and random checks against a slot/queue model ====
// ==== Rev 1.0                                                                       ====
`default_nettype none

module tb_nx_stream_combiner;
   import nx_stream_combiner_pkg::*;

   localparam int S = 4;

   logic                  clk;
   logic                  rst_n;
   logic                  idle;
   node_message_t [S-1:0] in_data;
   logic [S-1:0]          in_valid;
   logic [S-1:0]          in_rdy;
   direction_t            out_dir;
   node_message_t         out_data;
   logic                  out_valid;
   logic                  out_rdy;

   nx_stream_combiner #(.STREAMS(S)) dut (
      .i_clk            (clk),
      .i_rst            (rst_n),
      .o_idle           (idle),
      .i_inbound_data   (in_data),
      .i_inbound_valid  (in_valid),
      .o_inbound_ready  (in_rdy),
      .o_outbound_dir   (out_dir),
      .o_outbound_data  (out_data),
      .o_outbound_valid (out_valid),
      .i_outbound_ready (out_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one output slot plus the last granted stream.
   logic          m_valid;
   logic [31:0]   m_data;
   int            m_dir;
   int            last;
   int            wait_cnt [S];
   int            seq_next [S];
   int            pop_exp  [S];
   bit            rnd_phase;

   function automatic int exp_grant(input logic [S-1:0] v, input int lst);
`ifdef NX_STREAM_COMBINER_FIXED_PRIORITY_EN
      for (int i = 0; i < S; i++) if (v[i]) return i;
`else
      for (int k = 1; k <= S; k++) if (v[(lst + k) % S]) return (lst + k) % S;
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_dir   = 0;
      last    = S - 1;
      for (int i = 0; i < S; i++) wait_cnt[i] = 0;
   endtask

   // Inputs must be stable when called; returns at posedge+1.
   task automatic cycle();
      int         g;
      int         src;
      logic [S-1:0] exp_rdy;
      @(negedge clk);
      g       = exp_grant(in_valid, last);
      exp_rdy = ((!m_valid || out_rdy) && g >= 0) ? S'(1 << g) : '0;
      chk("ready", in_rdy, exp_rdy);
      chk("idle", idle, !m_valid && (in_valid == '0));
      chk("valid", out_valid, m_valid);
      if (m_valid) begin
         chk("data", out_data, m_data);
         chk("dir", out_dir, m_dir);
      end
      if (rnd_phase && m_valid && out_rdy) begin
         src = m_dir;
         chk("tag", out_data[31:24], src);
         chk("order", out_data[23:0], pop_exp[src]);
         pop_exp[src]++;
      end
      @(posedge clk);
      for (int i = 0; i < S; i++) if (!in_valid[i]) wait_cnt[i] = 0;
      if (exp_rdy != '0) begin
`ifndef NX_STREAM_COMBINER_FIXED_PRIORITY_EN
         for (int i = 0; i < S; i++) begin
            if (i == g) wait_cnt[i] = 0;
            else if (in_valid[i]) begin
               wait_cnt[i]++;
               chk("fair", wait_cnt[i] <= S - 1, 1);
            end
         end
`endif
         m_valid = 1'b1;
         m_data  = in_data[g];
         m_dir   = g;
         last    = g;
         if (rnd_phase) seq_next[g]++;
      end else if (out_rdy) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   int exp_src;

   initial begin
      in_valid  = '0;
      in_data   = '0;
      out_rdy   = 1'b0;
      rst_n     = 1'b0;
      rnd_phase = 1'b0;
      model_reset();
      for (int i = 0; i < S; i++) begin
         seq_next[i] = 0;
         pop_exp[i]  = 0;
      end
      #3;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_dir", out_dir, 0);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Idle, then a single south message
      out_rdy = 1'b1;
      cycle();
      chk("idle_after_rst", idle, 1);
      in_valid   = 4'b0100;
      in_data[2] = 32'h1234;
      #1 chk("south_ready", in_rdy, 4'b0100);
      cycle();
      in_valid = '0;
      #1;
      chk("south_valid", out_valid, 1);
      chk("south_data", out_data, 32'h1234);
      chk("south_dir", out_dir, DIRECTION_SOUTH);
      cycle();

      // All four valid, sink always ready
      for (int i = 0; i < S; i++) in_data[i] = 32'hA000_0000 + i;
      in_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         cycle();
         chk("rr_valid", out_valid, 1);
`ifdef NX_STREAM_COMBINER_FIXED_PRIORITY_EN
         chk("rr_dir", out_dir, 0);
`else
         chk("rr_dir", out_dir, (3 + k) % S);
`endif
      end

      // Backpressure with east and west requesting
      in_valid = 4'b1010;
      cycle();
`ifdef NX_STREAM_COMBINER_FIXED_PRIORITY_EN
      exp_src = 1;
`else
      exp_src = 3;
`endif
      out_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("bp_data", out_data, 32'hA000_0000 + exp_src);
         chk("bp_dir", out_dir, exp_src);
         chk("bp_rdy", in_rdy, 4'b0000);
      end
      out_rdy = 1'b1;
      for (int k = 0; k < 4; k++) cycle();

      // Pointer fairness after a west grant
      in_valid = '0;
      cycle();
      cycle();
      in_valid = 4'b1000;
      cycle();
      in_valid = 4'b1001;
      #1 chk("fair_first", in_rdy, 4'b0001);
      cycle();
`ifdef NX_STREAM_COMBINER_FIXED_PRIORITY_EN
      chk("fair_second", in_rdy, 4'b0001);
`else
      chk("fair_second", in_rdy, 4'b1000);
`endif
      cycle();
      in_valid = '0;
      cycle();
      cycle();

      // Asynchronous reset while a message is held
      in_valid = 4'b0110;
      cycle();
      chk("pre_rst_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_dir", out_dir, 0);
      model_reset();
      in_valid = 4'hF;
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 chk("arst_prio", in_rdy, 4'b0001);
      cycle();
      in_valid = '0;
      cycle();
      cycle();

      // Random traffic with per-source sequence tags
      rnd_phase = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         in_valid = S'($urandom);
         out_rdy  = ($urandom % 4) != 0;
         for (int i = 0; i < S; i++) in_data[i] = {8'(i), 24'(seq_next[i])};
         cycle();
      end
      in_valid = '0;
      out_rdy  = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      for (int i = 0; i < S; i++) chk("drained", pop_exp[i], seq_next[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nx_stream_combiner.md
Name: nx_stream_combiner

Overview:
Merges up to four inbound node message streams (north/east/south/west) into one outbound stream and tags each message with the direction it arrived from. It is the converse of nx_stream_distributor and sits at the node boundary, feeding a single decoder from the mesh links. Arbitration is round-robin and the output is registered.

Parameters:
STREAMS, 4, number of inbound streams (2..4); index i maps to direction_t value i (DIRECTION_NORTH=0 .. DIRECTION_WEST=3).

Ports:
i_clk  input  1  clock
i_rst  input  1  reset; asynchronous, active-low
o_idle  output  1  high when no message is held and no inbound valid is asserted
i_inbound_data  input  STREAMS x MESSAGE_WIDTH  per-stream message (node_message_t)
i_inbound_valid  input  STREAMS  per-stream valid
o_inbound_ready  output  STREAMS  per-stream ready
o_outbound_dir  output  direction_t (2)  source direction of the held message
o_outbound_data  output  MESSAGE_WIDTH  held message (node_message_t)
o_outbound_valid  output  1  held message valid
i_outbound_ready  input  1  downstream ready

Behaviour:
- Reset (i_rst low, async): o_outbound_valid=0, o_outbound_data=0, o_outbound_dir=0, RR pointer=STREAMS-1, so stream 0 has first priority. Asserting reset mid-transfer discards the held message.
- Output slot is one register (data, dir, valid). slot_free = !o_outbound_valid || i_outbound_ready.
- Arbitration (combinational): search i_inbound_valid from (ptr+1) upward, wrapping modulo STREAMS. The first valid index is the grant; the grant is one-hot or zero.
- o_inbound_ready[i] = slot_free && grant[i]. At most one ready is high per cycle.
- Ready depends combinationally on valid and on i_outbound_ready. Upstream valid must not depend on ready.
- Accept (valid && ready on stream g): on the next edge, data <= i_inbound_data[g], dir <= g, valid <= 1, ptr <= g. Latency is 1 cycle from accept to o_outbound_valid.
- Output handshake with no accept in that cycle: valid <= 0. Pop and accept in the same cycle: back-to-back, 1 message per cycle sustained.
- Output not ready while valid: the slot holds, data/dir are stable, and all o_inbound_ready are 0.
- ptr updates only on accept. With a single requester, the same stream is granted every cycle.
- Valid deasserted by upstream before ready: that stream is simply not granted. No data is latched.
- o_idle = !o_outbound_valid && !(|i_inbound_valid). Combinational; 1 after reset with inputs low.

Optional Feature:
NX_STREAM_COMBINER_FIXED_PRIORITY_EN
- Defined: the RR pointer is removed. The grant is the lowest valid index (north highest priority). Everything else is unchanged.
- Undefined: round-robin behaviour as above.

Decomposition:
- NXConstants package supplies node_message_t, MESSAGE_WIDTH, direction_t and the DIRECTION_* constants. No new typedefs are needed.
- One sub-module, nx_arbiter_rr (parameter WIDTH): inputs are the request vector and i_update/i_grant_idx; outputs are the one-hot grant and encoded index. It holds the pointer and shares the same reset.
- The fixed-priority macro is handled inside nx_arbiter_rr.

Test Plan:
1. Reset then idle: no valids -> o_outbound_valid=0, all o_inbound_ready=0, o_idle=1. Drive south valid with data 0x1234 -> ready[2]=1 the same cycle; the next cycle gives o_outbound_valid=1, data=0x1234, dir=DIRECTION_SOUTH.
2. All four valid continuously, i_outbound_ready=1 -> output dir sequence 0,1,2,3,0,1… with one message per cycle and no gaps. With FIXED_PRIORITY_EN: dir is always 0.
3. Backpressure: hold i_outbound_ready=0 for 5 cycles with east and west valid -> output data/dir stable, every o_inbound_ready=0. Releasing it resumes in RR order with nothing lost or duplicated.
4. Pointer fairness: after a grant to stream 3, streams 0 and 3 both valid -> stream 0 is granted first, then 3.
5. Async reset mid-stream: assert i_rst low between clock edges while o_outbound_valid=1 -> outputs clear immediately. After release, stream 0 has priority.
6. Random scoreboard: 10k cycles with random valids/ready -> every accepted message appears once in per-source order with the correct dir, and each stream waits at most STREAMS-1 grants.
